// File: rtl/logic_mux2_if.sv
// logic_mux2_if: operand/select/result bundle for logic_mux2.
// master drives a, b, c and reads y; slave is the mux side.
interface logic_mux2_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] y;

  modport master (
    output a,
    output b,
    output c,
    input  y
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output y
  );
endinterface

// File: rtl/logic_mux2.sv
// logic_mux2: registered 2:1 mux from explicit AND/OR/NOT gates.
// Ports: clk, rst (sync, active-high), bus.a/b/c in, bus.y out.
// LOGIC_MUX2_IN_REG_EN adds an input register stage (latency 2).
module logic_mux2 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  logic_mux2_if.slave  bus
);

  if (WIDTH < 1) begin : g_width_chk
    $error("logic_mux2: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic             c_s;

`ifdef LOGIC_MUX2_IN_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_s <= '0;
      b_s <= '0;
      c_s <= 1'b0;
    end else begin
      a_s <= bus.a;
      b_s <= bus.b;
      c_s <= bus.c;
    end
  end
`else
  assign a_s = bus.a;
  assign b_s = bus.b;
  assign c_s = bus.c;
`endif

  // One shared inverter feeds every bit cell.
  logic c_n;
  assign c_n = ~c_s;

  logic [WIDTH-1:0] y_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic t_a;
    logic t_b;
    assign t_a       = a_s[i] & c_n;
    assign t_b       = b_s[i] & c_s;
    assign y_next[i] = t_a | t_b;
  end

  logic [WIDTH-1:0] y_q;

  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_next;
  end

  assign bus.y = y_q;

endmodule

// File: tb/tb_logic_mux2.sv
// tb_logic_mux2: directed + random check of logic_mux2 at WIDTH 1 and 8.
// Reference: expected y = mux of inputs LAT edges back, 0 near reset.
module tb_logic_mux2;

`ifdef LOGIC_MUX2_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic_mux2_if #(.WIDTH(1)) i1 ();
  logic_mux2_if #(.WIDTH(8)) i8 ();

  logic_mux2 #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (i1.slave)
  );

  logic_mux2 #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (i8.slave)
  );

  typedef struct {
    logic       r;
    logic       a1;
    logic       b1;
    logic       c1;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       c8;
  } smp_t;

  smp_t hist[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step(
    input logic       r,
    input logic       a1,
    input logic       b1,
    input logic       c1,
    input logic [7:0] a8,
    input logic [7:0] b8,
    input logic       c8,
    input string      tag
  );
    smp_t       s;
    smp_t       old;
    logic       any_r;
    logic       e1;
    logic [7:0] e8;
    rst  = r;
    i1.a = a1;
    i1.b = b1;
    i1.c = c1;
    i8.a = a8;
    i8.b = b8;
    i8.c = c8;
    @(posedge clk);
    s = '{r: r, a1: a1, b1: b1, c1: c1, a8: a8, b8: b8, c8: c8};
    hist.push_front(s);
    if (hist.size() > LAT) void'(hist.pop_back());
    #1;
    // Result is valid only if no reset hit any stage it passed through.
    any_r = (hist.size() < LAT);
    foreach (hist[k]) if (hist[k].r) any_r = 1'b1;
    old = hist[hist.size() - 1];
    e1  = any_r ? 1'b0  : (old.c1 ? old.b1 : old.a1);
    e8  = any_r ? 8'h00 : (old.c8 ? old.b8 : old.a8);
    checks++;
    assert (i1.y === e1) else begin
      errors++;
      $error("FAIL %s w1: y=%b expected %b", tag, i1.y, e1);
    end
    checks++;
    assert (i8.y === e8) else begin
      errors++;
      $error("FAIL %s w8: y=%h expected %h", tag, i8.y, e8);
    end
  endtask

  initial begin
    logic       r;
    logic [7:0] ra;
    logic [7:0] rb;

    i1.a = 1'b0;
    i1.b = 1'b0;
    i1.c = 1'b0;
    i8.a = 8'h00;
    i8.b = 8'h00;
    i8.c = 1'b0;

    step(1, 1, 1, 1, 8'hFF, 8'hFF, 1, "reset0");
    step(1, 1, 1, 1, 8'hFF, 8'hFF, 1, "reset1");

    step(0, 1, 0, 0, 8'hA5, 8'h3C, 0, "sel_a");
    step(0, 1, 0, 0, 8'hA5, 8'h3C, 0, "sel_a_hold");
    step(0, 0, 1, 1, 8'hA5, 8'h3C, 1, "sel_b");
    step(0, 0, 1, 1, 8'hA5, 8'h3C, 1, "sel_b_hold");

    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(0, 1, 0, 0, 8'hA5, 8'h3C, 0, "alt_one");
      else            step(0, 0, 1, 1, 8'hA5, 8'h3C, 1, "alt_one");
    end
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(0, 0, 1, 0, 8'h3C, 8'hA5, 0, "alt_zero");
      else            step(0, 1, 0, 1, 8'h3C, 8'hA5, 1, "alt_zero");
    end

    step(0, 1, 0, 0, 8'hA5, 8'h3C, 0, "w8_pre");
    step(1, 1, 0, 0, 8'hA5, 8'h3C, 0, "mid_rst");
    step(0, 1, 0, 0, 8'hA5, 8'h3C, 0, "post_rst0");
    step(0, 1, 0, 0, 8'hA5, 8'h3C, 0, "post_rst1");
    step(0, 1, 0, 0, 8'hA5, 8'h3C, 0, "post_rst2");

    // Step c 0->1 with a=0, b=1 and watch the edge it lands on.
    step(0, 0, 1, 0, 8'h00, 8'hFF, 0, "lat_base");
    step(0, 0, 1, 0, 8'h00, 8'hFF, 0, "lat_base");
    step(0, 0, 1, 1, 8'h00, 8'hFF, 1, "lat_e1");
    step(0, 0, 1, 1, 8'h00, 8'hFF, 1, "lat_e2");
    step(0, 0, 1, 1, 8'h00, 8'hFF, 1, "lat_e3");

    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      step(r, 1'($urandom), 1'($urandom), 1'($urandom),
           ra, rb, 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
